// File: rtl/ctrl_encoder.sv
// Re-encodes a datapath control bundle back to its MIPS opcode and queues
// the tagged result in a small FIFO for valid/ready readout.
module ctrl_encoder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               ALUOp,
  input  logic [1:0]               RegDst,
  input  logic [1:0]               ALUSrc,
  input  logic                     MemToReg,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic                     RegWrite,
  input  logic                     Jal,
  input  logic                     Jump,
  input  logic                     BranchNe,
  input  logic                     Branch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_opcode,
  output logic                     out_illegal,
  output logic                     out_ambig,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 6 + 2 + SEQ_W;

  logic [5:0]       enc_op;
  logic             enc_ill;
  logic             enc_amb;
  logic             no_mem;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [SEQ_W-1:0] seq;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_nxt;

  assign no_mem = !MemRead && !MemWrite;

  // Priority-ordered match of the bundle against each decoder encoding.
  always_comb begin
    enc_op  = 6'h3F;
    enc_ill = 1'b1;
    enc_amb = 1'b0;
    if (Jump && Jal && RegWrite && RegDst == 2'b10) begin
      enc_op = 6'd3;  enc_ill = 1'b0;
    end else if (Jump && !Jal && !RegWrite && !MemWrite) begin
      enc_op = 6'd2;  enc_ill = 1'b0;
    end else if (!Jump && !Jal) begin
      if (Branch && !BranchNe && ALUOp == 3'b001 && !RegWrite && !MemWrite) begin
        enc_op = 6'd4;  enc_ill = 1'b0;
      end else if (BranchNe && !Branch && ALUOp == 3'b001 && !RegWrite && !MemWrite) begin
        enc_op = 6'd5;  enc_ill = 1'b0;
      end else if (MemWrite && !MemRead && !RegWrite && ALUOp == 3'b000 && ALUSrc == 2'b01) begin
        enc_op = 6'd43; enc_ill = 1'b0;
      end else if (MemRead && MemToReg && RegWrite && !MemWrite && ALUOp == 3'b000 &&
                   ALUSrc == 2'b01 && RegDst == 2'b00) begin
        enc_op = 6'd35; enc_ill = 1'b0;
      end else if (RegWrite && RegDst == 2'b01 && ALUOp == 3'b110 && ALUSrc == 2'b00 &&
                   !MemToReg && no_mem) begin
        enc_op = 6'd0;  enc_ill = 1'b0;
      end else if (RegWrite && RegDst == 2'b00 && !MemToReg && no_mem && !Branch && !BranchNe) begin
        // slti and sltiu drive identical bundles; report slti and flag it
        case ({ALUOp, ALUSrc})
          5'b000_01: begin enc_op = 6'd8;  enc_ill = 1'b0; end
          5'b101_01: begin enc_op = 6'd10; enc_ill = 1'b0; enc_amb = 1'b1; end
          5'b010_10: begin enc_op = 6'd12; enc_ill = 1'b0; end
          5'b011_10: begin enc_op = 6'd13; enc_ill = 1'b0; end
          5'b100_10: begin enc_op = 6'd14; enc_ill = 1'b0; end
          5'b000_11: begin enc_op = 6'd15; enc_ill = 1'b0; end
          default: ;
        endcase
      end
    end
  end

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Handshake flags are registered from next occupancy, so in_ready never
  // depends combinationally on out_ready.
  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      seq       <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq    <= seq + SEQ_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
      count     <= count_nxt;
      in_ready  <= count_nxt != CW'(DEPTH);
      out_valid <= count_nxt != '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && !clr && push) begin
      mem[wr_ptr] <= {enc_op, enc_ill, enc_amb, seq};
    end
  end

  assign {out_opcode, out_illegal, out_ambig, out_seq} = mem[rd_ptr];

endmodule

// File: tb/tb_ctrl_encoder.sv
// Bench for ctrl_encoder: a negedge scoreboard model of the FIFO plus
// directed scenario tasks with their own spot checks.
module tb_ctrl_encoder;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SEQ_W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready;
  logic [2:0] ALUOp = '0;
  logic [1:0] RegDst = '0;
  logic [1:0] ALUSrc = '0;
  logic MemToReg = 0, MemWrite = 0, MemRead = 0, RegWrite = 0;
  logic Jal = 0, Jump = 0, BranchNe = 0, Branch = 0;
  logic out_valid;
  logic [5:0] out_opcode;
  logic out_illegal;
  logic out_ambig;
  logic [SEQ_W-1:0] out_seq;
  logic [3:0] count;
  logic overflow;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad = 0;

  // Expected encoding of the bundle currently driven.
  logic [5:0] exp_op = '0;
  logic exp_ill = 1'b0;
  logic exp_amb = 1'b0;

  // Scoreboard model state.
  logic [15:0] sb[$];
  logic [7:0] m_seq = '0;
  logic m_ovf = 1'b0;
  logic [7:0] m_drop = '0;
  logic m_known = 1'b0;

  ctrl_encoder #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clock(clock), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemToReg(MemToReg), .MemWrite(MemWrite), .MemRead(MemRead), .RegWrite(RegWrite),
    .Jal(Jal), .Jump(Jump), .BranchNe(BranchNe), .Branch(Branch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_illegal(out_illegal), .out_ambig(out_ambig),
    .out_seq(out_seq), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  // Compare DUT against model, then advance model for the coming edge.
  always @(negedge clock) begin
    if (m_known) begin
      total++;
      if (count !== 4'(sb.size())) begin
        bad++; $display("FAIL sb_count got=%0d exp=%0d", count, sb.size());
      end
      total++;
      if (out_valid !== (sb.size() != 0)) begin
        bad++; $display("FAIL sb_out_valid got=%0b exp=%0b", out_valid, sb.size() != 0);
      end
      total++;
      if (in_ready !== (sb.size() != DEPTH)) begin
        bad++; $display("FAIL sb_in_ready got=%0b exp=%0b", in_ready, sb.size() != DEPTH);
      end
      total++;
      if (overflow !== m_ovf || drop_cnt !== m_drop) begin
        bad++; $display("FAIL sb_drop got=%0b/%0d exp=%0b/%0d", overflow, drop_cnt, m_ovf, m_drop);
      end
      if (sb.size() != 0) begin
        total++;
        if ({out_opcode, out_illegal, out_ambig, out_seq} !== sb[0]) begin
          bad++;
          $display("FAIL sb_head got=op%0d ill%0b amb%0b seq%0d exp=op%0d ill%0b amb%0b seq%0d",
                   out_opcode, out_illegal, out_ambig, out_seq,
                   sb[0][15:10], sb[0][9], sb[0][8], sb[0][7:0]);
        end
      end
    end
    if (!reset || clr) begin
      sb.delete(); m_seq = '0; m_ovf = 1'b0; m_drop = '0; m_known = 1'b1;
    end else if (m_known) begin
      automatic bit do_push = in_valid && sb.size() != DEPTH;
      automatic bit do_pop = out_ready && sb.size() != 0;
      if (in_valid && !do_push) begin
        m_ovf = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back({exp_op, exp_ill, exp_amb, m_seq});
        m_seq = m_seq + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bundles as produced by the opcode decoder, index 14 being illegal.
  task automatic load(input int idx);
    {ALUOp, RegDst, ALUSrc} = '0;
    {MemToReg, MemWrite, MemRead, RegWrite, Jal, Jump, BranchNe, Branch} = '0;
    exp_ill = 1'b0;
    exp_amb = 1'b0;
    case (idx)
      0:  begin RegWrite = 1; RegDst = 2'b01; ALUOp = 3'b110; exp_op = 6'd0; end
      1:  begin Branch = 1; ALUOp = 3'b001; exp_op = 6'd4; end
      2:  begin BranchNe = 1; ALUOp = 3'b001; exp_op = 6'd5; end
      3:  begin RegWrite = 1; ALUSrc = 2'b01; exp_op = 6'd8; end
      4, 5: begin RegWrite = 1; ALUOp = 3'b101; ALUSrc = 2'b01; exp_op = 6'd10; exp_amb = 1; end
      6:  begin RegWrite = 1; ALUOp = 3'b010; ALUSrc = 2'b10; exp_op = 6'd12; end
      7:  begin RegWrite = 1; ALUOp = 3'b011; ALUSrc = 2'b10; exp_op = 6'd13; end
      8:  begin RegWrite = 1; ALUOp = 3'b100; ALUSrc = 2'b10; exp_op = 6'd14; end
      9:  begin RegWrite = 1; ALUSrc = 2'b11; exp_op = 6'd15; end
      10: begin MemRead = 1; MemToReg = 1; RegWrite = 1; ALUSrc = 2'b01; exp_op = 6'd35; end
      11: begin MemWrite = 1; ALUSrc = 2'b01; exp_op = 6'd43; end
      12: begin Jump = 1; ALUOp = 3'($urandom); ALUSrc = 2'($urandom); exp_op = 6'd2; end
      13: begin Jump = 1; Jal = 1; RegWrite = 1; RegDst = 2'b10;
                ALUOp = 3'($urandom); ALUSrc = 2'($urandom); exp_op = 6'd3; end
      default: begin Branch = 1; BranchNe = 1; ALUOp = 3'b001; exp_op = 6'h3F; exp_ill = 1; end
    endcase
  endtask

  task automatic test_reset();
    reset = 0; in_valid = 1; out_ready = 1; load(10);
    tick(); tick();
    total++;
    if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_state got=cnt%0d ov%0b ir%0b of%0b dc%0d exp=cnt0 ov0 ir1 of0 dc0",
               count, out_valid, in_ready, overflow, drop_cnt);
    end
    reset = 1; in_valid = 0;
  endtask

  task automatic test_basic();
    out_ready = 1; in_valid = 1; load(10);
    tick();
    total++;
    if (out_valid !== 1'b1 || out_opcode !== 6'd35 || out_seq !== 8'd0) begin
      bad++; $display("FAIL basic_lw got=v%0b op%0d seq%0d exp=v1 op35 seq0", out_valid, out_opcode, out_seq);
    end
    load(13);
    tick();
    total++;
    if (out_valid !== 1'b1 || out_opcode !== 6'd3 || out_seq !== 8'd1) begin
      bad++; $display("FAIL basic_jal got=v%0b op%0d seq%0d exp=v1 op3 seq1", out_valid, out_opcode, out_seq);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_sweep();
    out_ready = 1;
    for (int i = 0; i < 15; i++) begin
      load(i); in_valid = 1; tick();
      total++;
      if (out_opcode !== exp_op || out_illegal !== exp_ill || out_ambig !== exp_amb) begin
        bad++; $display("FAIL sweep_%0d got=op%0d ill%0b amb%0b exp=op%0d ill%0b amb%0b",
                        i, out_opcode, out_illegal, out_ambig, exp_op, exp_ill, exp_amb);
      end
    end
    in_valid = 0;
    tick(); tick();
  endtask

  task automatic test_full();
    reset = 0; tick(); reset = 1;
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      load(i); in_valid = 1; tick();
    end
    in_valid = 0;
    total++;
    if (count !== 4'd8 || in_ready !== 1'b0 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      bad++; $display("FAIL full_state got=cnt%0d ir%0b of%0b dc%0d exp=cnt8 ir0 of1 dc2",
                      count, in_ready, overflow, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1; out_ready = 1; load(3);
    tick();
    total++;
    if (count !== 4'd7 || out_seq !== 8'd1) begin
      bad++; $display("FAIL full_pop got=cnt%0d seq%0d exp=cnt7 seq1", count, out_seq);
    end
    out_ready = 0; load(6);
    tick();
    total++;
    if (count !== 4'd8) begin
      bad++; $display("FAIL refill got=cnt%0d exp=cnt8", count);
    end
    in_valid = 0; out_ready = 1;
    repeat (10) tick();
    total++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL drain got=cnt%0d ov%0b exp=cnt0 ov0", count, out_valid);
    end
  endtask

  task automatic test_wrap_clr();
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 300; i++) begin
      load(int'($urandom_range(0, 14))); tick();
    end
    clr = 1; load(0);
    tick();
    clr = 0;
    total++;
    if (count !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL clr_state got=cnt%0d of%0b dc%0d ov%0b exp=cnt0 of0 dc0 ov0",
                      count, overflow, drop_cnt, out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_seq !== 8'd0 || out_opcode !== 6'd0) begin
      bad++; $display("FAIL clr_tag got=v%0b seq%0d op%0d exp=v1 seq0 op0", out_valid, out_seq, out_opcode);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_saturate();
    out_ready = 0; in_valid = 1; load(8);
    repeat (DEPTH + 260) tick();
    total++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1 || count !== 4'd8) begin
      bad++; $display("FAIL saturate got=dc%0d of%0b cnt%0d exp=dc255 of1 cnt8", drop_cnt, overflow, count);
    end
    reset = 0; out_ready = 1;
    tick();
    reset = 1; in_valid = 0;
    total++;
    if (count !== 4'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=cnt%0d dc%0d of%0b exp=cnt0 dc0 of0", count, drop_cnt, overflow);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_full();
    test_back_to_back();
    test_wrap_clr();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
